// File: rtl/ice40_ram_ctrl_if.sv
// Request/response stream bundle between user logic and ice40_ram_ctrl.
// Latency: none, wires only. Backpressure: req_ready stalls requests, rsp_ready stalls responses.
// Ports: master = user side (issues requests, consumes responses), slave = controller side.
interface ice40_ram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [15:0] req_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ice40_ram_ctrl.sv
// Front-end for one SB_RAM40_4K in 256x16 mode with an optional post-reset clear sweep.
// Latency: read accepted at edge t gives rsp_valid after edge t+1; writes produce no response.
// Backpressure: reads stall once FIFO occupancy plus the pending read would exceed 2; writes never stall.
// Ports: CLK/RESETN (sync, active-low), bus = request/response stream, busy = clear in progress,
//        RADDR/RE/RCLKE/WADDR/WDATA/MASK/WE/WCLKE drive the RAM, RDATA is its registered read data.
module ice40_ram_ctrl #(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [15:0] CLEAR_VALUE    = 16'h0000
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  ice40_ram_ctrl_if.slave       bus,
  output logic                  busy,
  output logic [10:0]           RADDR,
  output logic                  RE,
  output logic                  RCLKE,
  output logic [10:0]           WADDR,
  output logic [15:0]           WDATA,
  output logic [15:0]           MASK,
  output logic                  WE,
  output logic                  WCLKE,
  input  logic [15:0]           RDATA
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t      state, state_nxt;
  logic [7:0]  clr_cnt, clr_cnt_nxt;
  logic        rd_pend;
  logic        rd_acc;

  logic [15:0] fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        push, pop;
  logic [2:0]  occ;
  logic        can_read;

  // RDATA is valid exactly one cycle after the read strobe, so the delayed strobe is the push.
  assign push = rd_pend;
  assign pop  = bus.rsp_valid & bus.rsp_ready;

  // Reads in flight (in the RAM pipeline) count as occupied slots; a same-edge pop frees one.
  assign occ      = {1'b0, count} + {2'b00, rd_pend};
  assign can_read = occ < (3'd2 + {2'b00, pop});

  // Gated by RESETN so nothing is visible before the first reset edge flushes the FIFO.
  assign bus.rsp_valid = RESETN & (count != 2'd0);
  assign bus.rsp_data  = fifo_mem[rd_ptr];

  always_comb begin
    state_nxt     = state;
    clr_cnt_nxt   = clr_cnt;
    busy          = 1'b0;
    bus.req_ready = 1'b0;
    rd_acc        = 1'b0;
    RE            = 1'b0;
    RCLKE         = 1'b0;
    WE            = 1'b0;
    WCLKE         = 1'b0;
    RADDR         = {3'b000, bus.req_addr};
    WADDR         = {3'b000, bus.req_addr};
    WDATA         = bus.req_wdata;
    MASK          = bus.req_mask;

    if (RESETN) begin
      case (state)
        S_CLEAR: begin
          busy        = 1'b1;
          WE          = 1'b1;
          WCLKE       = 1'b1;
          WADDR       = {3'b000, clr_cnt};
          WDATA       = CLEAR_VALUE;
          MASK        = 16'h0000;
          clr_cnt_nxt = clr_cnt + 8'd1;
          if (clr_cnt == 8'hFF) state_nxt = S_RUN;
        end
        S_RUN: begin
          bus.req_ready = bus.req_we | can_read;
          if (bus.req_valid && bus.req_ready) begin
            if (bus.req_we) begin
              WE    = 1'b1;
              WCLKE = 1'b1;
            end else begin
              RE     = 1'b1;
              RCLKE  = 1'b1;
              rd_acc = 1'b1;
            end
          end
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      clr_cnt <= 8'd0;
      rd_pend <= 1'b0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      rd_pend <= rd_acc;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count   <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Data storage needs no reset; occupancy decides what is visible.
  always_ff @(posedge CLK) begin
    if (RESETN && push) fifo_mem[wr_ptr] <= RDATA;
  end

endmodule
